input_module: RTL and testbench



---
 rtl/input_module.sv | 51 +++++
 tb/tb_input_module.sv | 117 +++++++++++
 2 files changed

// File: rtl/input_module.sv
// input_module: NoC router input stage that registers the head flit and its XY-routed output direction.
module input_module #(
    parameter int MSB_SLOT = 5,
    parameter int DSIZE = 1 << MSB_SLOT,
    parameter int RRSIZE = 1 << (MSB_SLOT - 2),
    parameter logic [2:0] PORT = 3'b000,
    parameter logic [RRSIZE-1:0] ROUTER_X = '0,
    parameter logic [RRSIZE-1:0] ROUTER_Y = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DSIZE-1:0] data_in,
    input  logic             input_empty,
    input  logic             input_read,
    output logic [DSIZE-1:0] data_out,
    output logic [2:0]       vc_select
);
    localparam logic [2:0] DIR_N = 3'b000;
    localparam logic [2:0] DIR_S = 3'b001;
    localparam logic [2:0] DIR_E = 3'b010;
    localparam logic [2:0] DIR_W = 3'b011;
    localparam logic [2:0] DIR_L = 3'b100;
    localparam logic [2:0] DIR_INV = 3'b111;

    logic [RRSIZE-1:0] dest_x;
    logic [RRSIZE-1:0] dest_y;
    logic [2:0]        route;
    logic [2:0]        vc_next;

    assign dest_x = data_in[DSIZE/2 +: RRSIZE];
    assign dest_y = data_in[RRSIZE-1:0];

    always_comb begin
        route = dest_x > ROUTER_X ? DIR_E :
                dest_x < ROUTER_X ? DIR_W :
                dest_y > ROUTER_Y ? DIR_S :
                dest_y < ROUTER_Y ? DIR_N : DIR_L;
        // a flit may never leave through the port it arrived on
        vc_next = (route == PORT && PORT != DIR_L) ? DIR_INV : route;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            vc_select <= DIR_INV;
        end else if (input_read) begin
            if (!input_empty) data_out <= data_in;
            vc_select <= input_empty ? DIR_INV : vc_next;
        end
    end
endmodule

// File: tb/tb_input_module.sv
// tb_input_module: directed checks of routing, U-turn rejection, hold/empty behaviour and async reset.
module tb_input_module;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        input_empty;
    logic        input_read;
    logic [31:0] d0, d1, d2;
    logic [2:0]  v0, v1, v2;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    input_module #(.PORT(3'b000), .ROUTER_X(8'd0), .ROUTER_Y(8'd0)) u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
        .input_read(input_read), .data_out(d0), .vc_select(v0));
    input_module #(.PORT(3'b011), .ROUTER_X(8'd1), .ROUTER_Y(8'd0)) u1 (
        .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
        .input_read(input_read), .data_out(d1), .vc_select(v1));
    input_module #(.PORT(3'b000), .ROUTER_X(8'd0), .ROUTER_Y(8'd1)) u2 (
        .clk(clk), .reset(reset), .data_in(data_in), .input_empty(input_empty),
        .input_read(input_read), .data_out(d2), .vc_select(v2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        data_in = 32'h00010001;
        input_empty = 1'b0;
        input_read = 1'b0;
        repeat (2) step();
        check("reset_data", d0, 32'h0);
        check("reset_vc", {29'd0, v0}, 32'h7);
        reset = 1'b0;
        input_read = 1'b1;
        step();
        check("r00_data", d0, 32'h00010001);
        check("r00_east", {29'd0, v0}, 32'h2);
        check("r10_south", {29'd0, v1}, 32'h1);
        check("r01_east", {29'd0, v2}, 32'h2);
        data_in = 32'h00000001;
        step();
        check("r00_south", {29'd0, v0}, 32'h1);
        check("r10_uturn_w", {29'd0, v1}, 32'h7);
        check("r01_local", {29'd0, v2}, 32'h4);
        data_in = 32'h00000000;
        step();
        check("r00_local", {29'd0, v0}, 32'h4);
        check("r10_uturn", {29'd0, v1}, 32'h7);
        check("r01_uturn_n", {29'd0, v2}, 32'h7);
        data_in = 32'hAAAA0000;
        step();
        check("r10_east", {29'd0, v1}, 32'h2);
        check("r00_east_aa", {29'd0, v0}, 32'h2);
        check("r00_data_aa", d0, 32'hAAAA0000);
        input_read = 1'b0;
        data_in = 32'h12345678;
        step();
        input_empty = 1'b1;
        step();
        check("hold_data", d0, 32'hAAAA0000);
        check("hold_vc", {29'd0, v0}, 32'h2);
        input_read = 1'b1;
        step();
        check("empty_data", d0, 32'hAAAA0000);
        check("empty_vc", {29'd0, v0}, 32'h7);
        input_empty = 1'b0;
        data_in = 32'h00020003;
        step();
        check("b2b0_data", d0, 32'h00020003);
        check("b2b0_vc", {29'd0, v0}, 32'h2);
        data_in = 32'h00000005;
        step();
        check("b2b1_data", d0, 32'h00000005);
        check("b2b1_vc", {29'd0, v0}, 32'h1);
        data_in = 32'h00000000;
        step();
        check("b2b2_data", d0, 32'h00000000);
        check("b2b2_vc", {29'd0, v0}, 32'h4);
        data_in = 32'hFF00FF00;
        step();
        check("b2b3_data", d0, 32'hFF00FF00);
        check("b2b3_upper_ignored", {29'd0, v0}, 32'h4);
        data_in = 32'h00FF0100;
        step();
        check("pre_areset_data", d1, 32'h00FF0100);
        reset = 1'b1;
        #2;
        check("areset_data", d1, 32'h0);
        check("areset_vc", {29'd0, v1}, 32'h7);
        check("areset_vc_u0", {29'd0, v0}, 32'h7);
        reset = 1'b0;
        input_read = 1'b0;
        step();
        check("post_reset_hold", d0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
